load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-side load/store stage of the copperv core: turns one-cycle load/store requests
// into valid/ready bus transfers and returns a completion pulse plus the extended load result.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_data,
    input  logic              store_data,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [31:0]       store_din,
    output logic              data_valid,
    output logic [31:0]       load_dout,
    output logic              misaligned,
    output logic              dr_addr_valid,
    input  logic              dr_addr_ready,
    output logic [ADDR_W-1:0] dr_addr,
    input  logic              dr_data_valid,
    output logic              dr_data_ready,
    input  logic [DATA_W-1:0] dr_data,
    output logic              dw_valid,
    input  logic              dw_ready,
    output logic [ADDR_W-1:0] dw_addr,
    output logic [DATA_W-1:0] dw_data,
    output logic [3:0]        dw_strobe,
    input  logic              dw_resp_valid,
    output logic              dw_resp_ready
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

    state_t      state;
    logic [1:0]  req_off;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        req_accept;
    logic        req_misaligned;
    logic [ADDR_W-1:0] bus_addr;

    // Size encoding 3 is reserved and behaves as a word everywhere (size[1] set).
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        if (size[1])
            return off != 2'b00;
        else if (size[0])
            return off[0];
        else
            return 1'b0;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        if (size[1])
            return word;
        else if (size[0])
            return {{16{h[15] & ~uns}}, h};
        else
            return {{24{b[7] & ~uns}}, b};
    endfunction

    function automatic logic [31:0] replicate_store(input logic [31:0] din, input logic [1:0] size);
        if (size[1])
            return din;
        else if (size[0])
            return {2{din[15:0]}};
        else
            return {4{din[7:0]}};
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] off);
        if (size[1])
            return 4'b1111;
        else if (size[0])
            return 4'b0011 << off;
        else
            return 4'b0001 << off;
    endfunction

    assign req_accept     = (state == IDLE) && (load_data || store_data);
    assign req_misaligned = is_misaligned(mem_size, addr[1:0]);
    assign bus_addr       = {addr[ADDR_W-1:2], 2'b00};

    // Request capture: data-only registers, frozen outside IDLE so bus fields stay stable.
    always_ff @(posedge clk) begin
        if (req_accept) begin
            req_off      <= addr[1:0];
            req_size     <= mem_size;
            req_unsigned <= mem_unsigned;
            dr_addr      <= bus_addr;
            dw_addr      <= bus_addr;
            dw_data      <= replicate_store(store_din, mem_size);
        end
    end

    // Control FSM with registered bus handshakes and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dr_addr_valid <= 1'b0;
            dr_data_ready <= 1'b0;
            dw_valid      <= 1'b0;
            dw_resp_ready <= 1'b0;
            data_valid    <= 1'b0;
            misaligned    <= 1'b0;
            load_dout     <= '0;
            dw_strobe     <= '0;
        end else begin
            data_valid <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_accept) begin
                        if (req_misaligned) begin
                            state      <= DONE;
                            data_valid <= 1'b1;
                            misaligned <= 1'b1;
                            if (load_data)
                                load_dout <= '0;
                        end else if (load_data) begin
                            state         <= RD_ADDR;
                            dr_addr_valid <= 1'b1;
                        end else begin
                            state     <= WR_REQ;
                            dw_valid  <= 1'b1;
                            dw_strobe <= store_strobe(mem_size, addr[1:0]);
                        end
                    end
                end
                RD_ADDR: begin
                    if (dr_addr_ready) begin
                        state         <= RD_DATA;
                        dr_addr_valid <= 1'b0;
                        dr_data_ready <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (dr_data_valid) begin
                        state         <= DONE;
                        dr_data_ready <= 1'b0;
                        data_valid    <= 1'b1;
                        load_dout     <= extend_load(dr_data, req_off, req_size, req_unsigned);
                    end
                end
                WR_REQ: begin
                    if (dw_ready) begin
                        state         <= WR_RESP;
                        dw_valid      <= 1'b0;
                        dw_resp_ready <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (dw_resp_valid) begin
                        state         <= DONE;
                        dw_resp_ready <= 1'b0;
                        data_valid    <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single transactions driven through a small
// bus responder, plus hand-written stall, ignored-request and mid-transaction reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_data, store_data;
    logic [31:0] addr;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] store_din;
    logic        data_valid;
    logic [31:0] load_dout;
    logic        misaligned;
    logic        dr_addr_valid, dr_addr_ready;
    logic [31:0] dr_addr;
    logic        dr_data_valid, dr_data_ready;
    logic [31:0] dr_data;
    logic        dw_valid, dw_ready;
    logic [31:0] dw_addr, dw_data;
    logic [3:0]  dw_strobe;
    logic        dw_resp_valid, dw_resp_ready;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .load_data(load_data), .store_data(store_data), .addr(addr),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .store_din(store_din),
        .data_valid(data_valid), .load_dout(load_dout), .misaligned(misaligned),
        .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
        .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
        .dw_valid(dw_valid), .dw_ready(dw_ready), .dw_addr(dw_addr), .dw_data(dw_data),
        .dw_strobe(dw_strobe), .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] din;
        logic [31:0] rdata;
        int          lat;
        logic        mis;
        logic [31:0] dout;
        logic        rd;
        logic [31:0] raddr;
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic bus_idle();
        load_data     = 1'b0;
        store_data    = 1'b0;
        dr_addr_ready = 1'b0;
        dr_data_valid = 1'b0;
        dr_data       = 32'h0;
        dw_ready      = 1'b0;
        dw_resp_valid = 1'b0;
    endtask

    // Issue one request and act as the bus; awt/dwt are wait cycles before the
    // request-side ready and the data/response valid. poke pulses load_data in RD_DATA.
    task automatic run_txn(input string tag, input vec_t v, input int awt, input int dwt,
                           input bit poke);
        int lat = -1;
        int acnt = 0;
        int dcnt = 0;
        bit saw_rd = 0, saw_wr = 0, stable = 1, poked = 0;
        logic [31:0] ra = '0, wa = '0, wd = '0;
        logic [3:0]  ws = '0;
        logic        mis = 1'b0;
        logic [31:0] dout = '0;
        @(negedge clk);
        load_data = v.ld; store_data = v.st; addr = v.a;
        mem_size = v.sz; mem_unsigned = v.uns; store_din = v.din;
        @(negedge clk);
        load_data = 1'b0; store_data = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (dr_addr_valid) begin
                if (!saw_rd) begin saw_rd = 1; ra = dr_addr; end
                else if (dr_addr !== ra) stable = 0;
            end
            if (dw_valid) begin
                if (!saw_wr) begin saw_wr = 1; wa = dw_addr; wd = dw_data; ws = dw_strobe; end
                else if (dw_addr !== wa || dw_data !== wd || dw_strobe !== ws) stable = 0;
            end
            if (data_valid) begin
                lat = k; mis = misaligned; dout = load_dout;
                break;
            end
            dr_addr_ready = dr_addr_valid && (acnt >= awt);
            dw_ready      = dw_valid && (acnt >= awt);
            if ((dr_addr_valid || dw_valid) && acnt < awt) acnt++;
            dr_data_valid = dr_data_ready && (dcnt >= dwt);
            dw_resp_valid = dw_resp_ready && (dcnt >= dwt);
            dr_data       = v.rdata;
            if ((dr_data_ready || dw_resp_ready) && dcnt < dwt) dcnt++;
            load_data = poke && dr_data_ready && !poked;
            if (load_data) begin poked = 1; addr = 32'h0000_0999; end
            @(negedge clk);
        end
        bus_idle();
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        chk({tag, " misaligned"}, {31'b0, mis}, {31'b0, v.mis});
        chk({tag, " read channel used"}, {31'b0, saw_rd}, {31'b0, v.rd});
        chk({tag, " write channel used"}, {31'b0, saw_wr}, {31'b0, v.wr});
        chk({tag, " fields stable"}, {31'b0, stable}, 32'd1);
        if (v.rd) chk({tag, " dr_addr"}, ra, v.raddr);
        if (v.wr) begin
            chk({tag, " dw_addr"}, wa, v.waddr);
            chk({tag, " dw_data"}, wd, v.wdata);
            chk({tag, " dw_strobe"}, {28'b0, ws}, {28'b0, v.wstrb});
        end
        if (v.ld) chk({tag, " load_dout"}, dout, v.dout);
    endtask

    initial begin
        //               ld    st    addr          sz    uns   din           rdata         lat mis   dout          rd    raddr         wr    waddr         wdata         strb
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0,        32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0103, 2'd0, 1'b0, 32'h0,        32'h8011_2233, 3, 1'b0, 32'hFFFF_FF80, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0103, 2'd0, 1'b1, 32'h0,        32'h8011_2233, 3, 1'b0, 32'h0000_0080, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0102, 2'd1, 1'b0, 32'h0,        32'h8011_2233, 3, 1'b0, 32'hFFFF_8011, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0102, 2'd1, 1'b1, 32'h0,        32'h8011_2233, 3, 1'b0, 32'h0000_8011, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0100, 2'd0, 1'b0, 32'h0,        32'h8011_2233, 3, 1'b0, 32'h0000_0033, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0102, 2'd2, 1'b0, 32'h0,        32'h1234_5678, 1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 4'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0300, 2'd2, 1'b0, 32'h1234_5678, 32'h0,        3, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0300, 32'h1234_5678, 4'hF};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0202, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0,        3, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0200, 32'hBEEF_BEEF, 4'hC};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0044, 2'd3, 1'b0, 32'h0,        32'h1122_3344, 3, 1'b0, 32'h1122_3344, 1'b1, 32'h0000_0044, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0101, 2'd1, 1'b0, 32'h0,        32'h1234_5678, 1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 4'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0206, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'h0,        1, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 4'h0};
        vecs[12] = '{1'b1, 1'b1, 32'h0000_0040, 2'd2, 1'b0, 32'h5555_5555, 32'h0BAD_F00D, 3, 1'b0, 32'h0BAD_F00D, 1'b1, 32'h0000_0040, 1'b0, 32'h0, 32'h0, 4'h0};

        bus_idle();
        addr = '0; mem_size = '0; mem_unsigned = 1'b0; store_din = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset handshakes", {26'b0, dr_addr_valid, dr_data_ready, dw_valid, dw_resp_ready,
                                 data_valid, misaligned}, 32'h0);
        chk("reset load_dout", load_dout, 32'h0);
        chk("reset dw_strobe", {28'b0, dw_strobe}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++)
            run_txn($sformatf("vec%0d", i), vecs[i], 0, 0, 1'b0);

        // SB with dw_ready held low for three cycles.
        run_txn("sb stall", '{1'b0, 1'b1, 32'h0000_0201, 2'd0, 1'b0, 32'h0000_00A5, 32'h0, 6, 1'b0,
                 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 4'h2}, 3, 0, 1'b0);

        // A load pulsed while waiting in RD_DATA must be ignored.
        run_txn("poke", '{1'b1, 1'b0, 32'h0000_0080, 2'd2, 1'b0, 32'h0, 32'h7777_1111, 5, 1'b0,
                 32'h7777_1111, 1'b1, 32'h0000_0080, 1'b0, 32'h0, 32'h0, 4'h0}, 0, 2, 1'b1);
        begin
            bit busy = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (dr_addr_valid || dw_valid || data_valid) busy = 1;
            end
            chk("poke ignored", {31'b0, busy}, 32'h0);
        end

        // Reset while waiting in RD_DATA aborts without a completion.
        begin
            bit reached = 0;
            bit late_done = 0;
            @(negedge clk);
            load_data = 1'b1; addr = 32'h0000_0500; mem_size = 2'd2; mem_unsigned = 1'b0;
            @(negedge clk);
            load_data = 1'b0;
            for (int k = 0; k < 10; k++) begin
                dr_addr_ready = dr_addr_valid;
                if (dr_data_ready) begin reached = 1; break; end
                @(negedge clk);
            end
            dr_addr_ready = 1'b0;
            chk("rst reached rd_data", {31'b0, reached}, 32'd1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rst aborts handshakes", {26'b0, dr_addr_valid, dr_data_ready, dw_valid, dw_resp_ready,
                                          data_valid, misaligned}, 32'h0);
            dr_data_valid = 1'b1; dr_data = 32'hFFFF_FFFF;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (data_valid || dr_data_ready) late_done = 1;
            end
            dr_data_valid = 1'b0;
            chk("rst stale beat ignored", {31'b0, late_done}, 32'h0);
            chk("rst load_dout cleared", load_dout, 32'h0);
        end
        run_txn("after rst", '{1'b1, 1'b0, 32'h0000_0104, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 3, 1'b0,
                 32'hCAFE_F00D, 1'b1, 32'h0000_0104, 1'b0, 32'h0, 32'h0, 4'h0}, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
